hl_mac_acc: RTL

Hidden-layer neuron accumulator for the MNIST inference datapath. It takes a bias plus a stream of N_IN (pixel, weight) pairs and computes bias + sum(pixel*weight), saturated to 32-bit signed. The result is the hl_buf word consumed combinationally by PE_relu downstream. One instance computes one neuron at a time; the controller re-starts it per neuron.

---
 rtl/mnist_pkg.sv | 16 +
 rtl/sat_trunc.sv | 24 ++
 rtl/hl_mac_acc.sv | 116 +++++++++++
 3 files changed

// File: rtl/mnist_pkg.sv
// Shared constants and FSM state type for the MNIST accumulator datapath.
package mnist_pkg;

  localparam int unsigned N_IN_HL = 784;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned W_W     = 8;
  localparam int unsigned ACC_W   = 40;
  localparam int unsigned OUT_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_trunc.sv
// Combinational signed saturation from IN_W bits down to OUT_W bits.
module sat_trunc #(
  parameter int unsigned IN_W  = 40,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]  i_din,
  output logic [OUT_W-1:0] o_dout
);

  // Bits that must all equal the sign for the value to fit in OUT_W.
  logic [IN_W-OUT_W:0] w_hi;

  assign w_hi = i_din[IN_W-1:OUT_W-1];

  // Pass through when representable, otherwise clamp to the signed limit.
  always_comb begin
    o_dout = i_din[OUT_W-1:0];
    if (!((&w_hi) || !(|w_hi))) begin
      if (i_din[IN_W-1]) o_dout = {1'b1, {(OUT_W-1){1'b0}}};
      else               o_dout = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/hl_mac_acc.sv
// Hidden-layer neuron accumulator: bias + sum(pixel*weight), saturated to OUT_W.
module hl_mac_acc
  import mnist_pkg::*;
#(
  parameter int unsigned N_IN  = mnist_pkg::N_IN_HL,
  parameter int unsigned PIX_W = mnist_pkg::PIX_W,
  parameter int unsigned W_W   = mnist_pkg::W_W,
  parameter int unsigned ACC_W = mnist_pkg::ACC_W,
  parameter int unsigned OUT_W = mnist_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OUT_W-1:0] bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] pixel,
  input  logic [W_W-1:0]   weight,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] hl_buf,
  output logic             busy
);

  localparam int unsigned CNT_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned PROD_W = PIX_W + W_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);

  state_t r_state, w_state_nxt;

  logic signed [ACC_W-1:0]  r_acc;
  logic        [CNT_W-1:0]  r_cnt;
  logic        [OUT_W-1:0]  r_hl_buf;

  logic                     w_accept;
  logic                     w_last;
  logic signed [PROD_W-1:0] w_pix_ext;
  logic signed [PROD_W-1:0] w_wt_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_bias_ext;
  logic        [OUT_W-1:0]  w_sat;

  // Pixel is unsigned: zero-extend; weight is signed: sign-extend. The
  // 17-bit product of the extended operands is exact.
  assign w_pix_ext  = {{(W_W + 1){1'b0}}, pixel};
  assign w_wt_ext   = {{(PIX_W + 1){weight[W_W-1]}}, weight};
  assign w_prod     = w_pix_ext * w_wt_ext;
  assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_sum      = r_acc + w_prod_ext;
  assign w_bias_ext = {{(ACC_W - OUT_W){bias[OUT_W-1]}}, bias};

  assign w_accept = (r_state == ACC) && in_valid;
  assign w_last   = (r_cnt == LAST);
  assign hl_buf   = r_hl_buf;

  sat_trunc #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .i_din  (w_sum),
    .o_dout (w_sat)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && w_last) w_state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Accumulator, beat counter and the saturated result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_hl_buf <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_acc <= w_bias_ext;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      if (w_last) begin
        r_hl_buf <= w_sat;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
